microprocessor_sequencer: RTL and testbench
===========================================

# microprocessor_sequencer

Sequences the programmable 8-bit microprocessor on behalf of a host command port (Raspberry Pi bridge side). Accepts one command at a time over a valid/ready handshake and drives the operands onto the processor. For an execute command it pulses GO_BAR and tracks MICROADDRESS until the microprogram returns to its idle address, then returns DATA_OUT over a result handshake. A timeout watchdog recovers a hung microprogram by pulsing the processor reset.

## Interface
Parameters:
- IDLE_ADDR, 8'h00, microaddress the control store rests at between instructions
- GO_CYCLES, 2, cycles GO_BAR is held low per launch (legal 1..15)
- TIMEOUT, 255, max cycles spent in LEAVE+RUN before abort (legal 1..255)

Ports:
- SYSTEM_CLK  in  1  single clock, all logic rising-edge
- RESET_BAR  in  1  asynchronous, active-low reset
- CMD_VALID  in  1  host command valid
- CMD_READY  out  1  sequencer can accept a command
- CMD_JAM  in  1  1 = jam command, 0 = execute command
- CMD_OPCODE  in  4  opcode
- CMD_A  in  8  operand A
- CMD_B  in  8  operand B
- RSP_VALID  out  1  result valid
- RSP_READY  in  1  host accepts result
- RSP_DATA  out  8  result byte
- RSP_TIMEOUT  out  1  result is a timeout abort
- OPCODE  out  4  to processor
- DATA_IN_A  out  8  to processor
- DATA_IN_B  out  8  to processor
- GO_BAR  out  1  active-low go to processor
- JAM  out  1  jam strobe to processor
- PROC_RESET  out  1  active-high reset to processor
- MICROADDRESS  in  8  from processor
- DATA_OUT  in  8  from processor
- BUSY  out  1  high in every state except IDLE

## Operation
- States: IDLE, LAUNCH, LEAVE, RUN, JAMMING, ABORT, RESPOND.
- Reset values, forced while RESET_BAR is low:
  - CMD_READY=0, RSP_VALID=0, RSP_DATA=0, RSP_TIMEOUT=0, OPCODE=0, DATA_IN_A=0, DATA_IN_B=0, JAM=0, BUSY=0.
  - GO_BAR=1, PROC_RESET=1, state IDLE, counters 0.
- PROC_RESET clears at the first clock edge after RESET_BAR releases.
- CMD_READY is high only in IDLE. It is driven from state only, with no dependence on CMD_VALID.
- Accept occurs when CMD_VALID and CMD_READY are both high at a clock edge:
  - OPCODE, DATA_IN_A and DATA_IN_B are registered from the command.
  - These outputs hold until the next accept. Neither reset abort nor jam changes them.
- Execute path (CMD_JAM=0):
  - IDLE -> LAUNCH. GO_BAR=0 for exactly GO_CYCLES cycles, then LEAVE.
  - LEAVE: wait for MICROADDRESS != IDLE_ADDR, then RUN.
  - RUN: wait for MICROADDRESS == IDLE_ADDR. At that edge, RSP_DATA<=DATA_OUT, RSP_TIMEOUT<=0, go to RESPOND.
- Jam path (CMD_JAM=1): IDLE -> JAMMING. JAM=1 for one cycle, then RESPOND with RSP_DATA=8'h00 and RSP_TIMEOUT=0.
- Watchdog:
  - 8-bit counter, cleared on entering LEAVE, increments every cycle in LEAVE and RUN.
  - When the count equals TIMEOUT-1 and the exit condition is not met, go to ABORT. The exit condition wins if both occur on the same edge.
- ABORT: PROC_RESET=1 for one cycle, RSP_DATA<=0, RSP_TIMEOUT<=1, then RESPOND.
- RESPOND:
  - RSP_VALID=1. RSP_DATA and RSP_TIMEOUT stay stable until the handshake.
  - On RSP_VALID and RSP_READY at an edge: go to IDLE, and RSP_VALID is 0 the next cycle.
  - RSP_DATA and RSP_TIMEOUT retain their last values after the handshake.
- Commands presented while not in IDLE are ignored (CMD_READY=0). The host must hold them.
- RESET_BAR asserted in any state immediately forces the reset values, including mid-LAUNCH with GO_BAR low and mid-RESPOND with a pending result. The pending result is lost.

## Timing
- Accept at edge E0. GO_BAR is low for cycles E0+1 .. E0+GO_CYCLES and LEAVE begins at E0+GO_CYCLES+1.
- Minimum execute latency, accept edge to RSP_VALID high:
  - GO_CYCLES + 3 cycles. This is 5 cycles at default GO_CYCLES=2.
  - It applies when MICROADDRESS leaves idle on the first LEAVE cycle and returns on the first RUN cycle.
- Jam latency: JAM is high at E0+1 and RSP_VALID is high at E0+2.
- Abort latency: TIMEOUT cycles in LEAVE+RUN, then 1 ABORT cycle, then RSP_VALID.
- Back-to-back throughput: with RSP_READY tied high, the next command can be accepted 1 cycle after the response handshake, because IDLE lasts one cycle.
- All outputs are registered.

## Test plan
- Reset: RESET_BAR low then released.
  - During reset: GO_BAR=1, PROC_RESET=1, CMD_READY=0.
  - After the first edge: PROC_RESET=0, CMD_READY=1, BUSY=0.
- Execute: CMD opcode=4'h3, A=8'h12, B=8'h34. Model MICROADDRESS leaving IDLE_ADDR 1 cycle after GO and returning after 6 cycles with DATA_OUT=8'h46.
  - GO_BAR low exactly 2 cycles.
  - RSP_VALID with RSP_DATA=8'h46, RSP_TIMEOUT=0.
  - OPCODE/DATA_IN_A/DATA_IN_B = 3/12/34 throughout.
- Backpressure: hold RSP_READY=0 for 10 cycles after RSP_VALID.
  - RSP_DATA is stable and CMD_READY=0 throughout.
  - Handshake then gives RSP_VALID=0 and CMD_READY=1 on the next cycle.
- Timeout: MICROADDRESS stuck at IDLE_ADDR with TIMEOUT=255.
  - Exactly 255 LEAVE cycles, then PROC_RESET pulses for 1 cycle.
  - Response is RSP_DATA=8'h00, RSP_TIMEOUT=1.
- Jam: CMD_JAM=1.
  - JAM=1 for exactly one cycle and GO_BAR stays 1.
  - Response is RSP_DATA=8'h00, 2 cycles after accept.
- Mid-operation reset: drop RESET_BAR while GO_BAR=0.
  - GO_BAR=1 immediately and RSP_VALID=0.
  - The next accepted command completes normally.

Source files
------------

// File: rtl/microprocessor_sequencer.sv
// Host-side sequencer for the programmable 8-bit microprocessor.
// Takes one command at a time, drives the operands onto the processor,
// launches an execute (GO_BAR pulse) or a jam, follows MICROADDRESS until
// the microprogram returns to its idle address, and hands back DATA_OUT.
// A watchdog aborts a hung microprogram by pulsing PROC_RESET.
module microprocessor_sequencer #(
  parameter logic [7:0] IDLE_ADDR = 8'h00,
  parameter int         GO_CYCLES = 2,
  parameter int         TIMEOUT   = 255
) (
  input  logic       SYSTEM_CLK,
  input  logic       RESET_BAR,
  input  logic       CMD_VALID,
  output logic       CMD_READY,
  input  logic       CMD_JAM,
  input  logic [3:0] CMD_OPCODE,
  input  logic [7:0] CMD_A,
  input  logic [7:0] CMD_B,
  output logic       RSP_VALID,
  input  logic       RSP_READY,
  output logic [7:0] RSP_DATA,
  output logic       RSP_TIMEOUT,
  output logic [3:0] OPCODE,
  output logic [7:0] DATA_IN_A,
  output logic [7:0] DATA_IN_B,
  output logic       GO_BAR,
  output logic       JAM,
  output logic       PROC_RESET,
  input  logic [7:0] MICROADDRESS,
  input  logic [7:0] DATA_OUT,
  output logic       BUSY
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_LEAVE,
    S_RUN,
    S_JAMMING,
    S_ABORT,
    S_RESPOND
  } state_t;

  // Last value of each counter before its phase ends.
  localparam logic [3:0] GO_LAST = 4'(GO_CYCLES - 1);
  localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);

  state_t     state_reg, state_next;
  logic [3:0] go_cnt_reg;
  logic [7:0] wd_cnt_reg;

  logic       accept;
  logic       at_idle_addr;
  logic       wd_expired;

  logic       cmd_ready_next;
  logic       rsp_valid_next;
  logic       go_bar_next;
  logic       jam_next;
  logic       proc_reset_next;
  logic       busy_next;
  logic [7:0] rsp_data_next;
  logic       rsp_timeout_next;
  logic [3:0] opcode_next;
  logic [7:0] data_in_a_next;
  logic [7:0] data_in_b_next;

  // The registered CMD_READY doubles as the "in IDLE and out of reset" flag,
  // so the accept condition matches exactly what the host observes.
  assign accept       = CMD_VALID && CMD_READY;
  assign at_idle_addr = (MICROADDRESS == IDLE_ADDR);
  assign wd_expired   = (wd_cnt_reg == WD_LAST);

  // State register.
  always_ff @(posedge SYSTEM_CLK or negedge RESET_BAR) begin
    if (!RESET_BAR) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic; a legitimate exit always beats the watchdog on the same edge.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: begin
        if (accept) begin
          state_next = CMD_JAM ? S_JAMMING : S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        if (go_cnt_reg == GO_LAST) begin
          state_next = S_LEAVE;
        end
      end
      S_LEAVE: begin
        if (!at_idle_addr) begin
          state_next = S_RUN;
        end else if (wd_expired) begin
          state_next = S_ABORT;
        end
      end
      S_RUN: begin
        if (at_idle_addr) begin
          state_next = S_RESPOND;
        end else if (wd_expired) begin
          state_next = S_ABORT;
        end
      end
      S_JAMMING: state_next = S_RESPOND;
      S_ABORT:   state_next = S_RESPOND;
      S_RESPOND: begin
        if (RSP_VALID && RSP_READY) begin
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // GO_BAR length counter and LEAVE+RUN watchdog; both rest at zero outside their phase.
  always_ff @(posedge SYSTEM_CLK or negedge RESET_BAR) begin
    if (!RESET_BAR) begin
      go_cnt_reg <= '0;
      wd_cnt_reg <= '0;
    end else begin
      go_cnt_reg <= (state_reg == S_LAUNCH) ? go_cnt_reg + 4'd1 : 4'd0;
      wd_cnt_reg <= (state_reg == S_LEAVE || state_reg == S_RUN) ? wd_cnt_reg + 8'd1 : 8'd0;
    end
  end

  // Output decode from the upcoming state so every output comes straight off a flop.
  always_comb begin
    cmd_ready_next   = (state_next == S_IDLE);
    rsp_valid_next   = (state_next == S_RESPOND);
    go_bar_next      = (state_next != S_LAUNCH);
    jam_next         = (state_next == S_JAMMING);
    proc_reset_next  = (state_next == S_ABORT);
    busy_next        = (state_next != S_IDLE);

    rsp_data_next    = RSP_DATA;
    rsp_timeout_next = RSP_TIMEOUT;
    if (state_reg == S_RUN && state_next == S_RESPOND) begin
      rsp_data_next    = DATA_OUT;
      rsp_timeout_next = 1'b0;
    end else if (state_reg == S_JAMMING) begin
      rsp_data_next    = 8'h00;
      rsp_timeout_next = 1'b0;
    end else if (state_next == S_ABORT) begin
      rsp_data_next    = 8'h00;
      rsp_timeout_next = 1'b1;
    end

    opcode_next    = accept ? CMD_OPCODE : OPCODE;
    data_in_a_next = accept ? CMD_A      : DATA_IN_A;
    data_in_b_next = accept ? CMD_B      : DATA_IN_B;
  end

  // Output registers; reset leaves the processor held in reset with GO released.
  always_ff @(posedge SYSTEM_CLK or negedge RESET_BAR) begin
    if (!RESET_BAR) begin
      CMD_READY   <= 1'b0;
      RSP_VALID   <= 1'b0;
      RSP_DATA    <= 8'h00;
      RSP_TIMEOUT <= 1'b0;
      OPCODE      <= 4'h0;
      DATA_IN_A   <= 8'h00;
      DATA_IN_B   <= 8'h00;
      GO_BAR      <= 1'b1;
      JAM         <= 1'b0;
      PROC_RESET  <= 1'b1;
      BUSY        <= 1'b0;
    end else begin
      CMD_READY   <= cmd_ready_next;
      RSP_VALID   <= rsp_valid_next;
      RSP_DATA    <= rsp_data_next;
      RSP_TIMEOUT <= rsp_timeout_next;
      OPCODE      <= opcode_next;
      DATA_IN_A   <= data_in_a_next;
      DATA_IN_B   <= data_in_b_next;
      GO_BAR      <= go_bar_next;
      JAM         <= jam_next;
      PROC_RESET  <= proc_reset_next;
      BUSY        <= busy_next;
    end
  end

endmodule

// File: tb/tb_microprocessor_sequencer.sv
// Bench for microprocessor_sequencer: directed steps plus randomized commands.
// A small processor model answers GO_BAR by walking MICROADDRESS away from and
// back to idle; expected results come from cycle arithmetic on that schedule.
module tb_microprocessor_sequencer;

  localparam int         G       = 2;
  localparam int         T       = 255;
  localparam logic [7:0] IDLE_MA = 8'h00;

  logic       SYSTEM_CLK = 1'b0;
  logic       RESET_BAR  = 1'b1;
  logic       CMD_VALID  = 1'b0;
  logic       CMD_READY;
  logic       CMD_JAM    = 1'b0;
  logic [3:0] CMD_OPCODE = 4'h0;
  logic [7:0] CMD_A      = 8'h00;
  logic [7:0] CMD_B      = 8'h00;
  logic       RSP_VALID;
  logic       RSP_READY  = 1'b0;
  logic [7:0] RSP_DATA;
  logic       RSP_TIMEOUT;
  logic [3:0] OPCODE;
  logic [7:0] DATA_IN_A;
  logic [7:0] DATA_IN_B;
  logic       GO_BAR;
  logic       JAM;
  logic       PROC_RESET;
  logic [7:0] MICROADDRESS = IDLE_MA;
  logic [7:0] DATA_OUT     = 8'h00;
  logic       BUSY;

  int n_checks = 0;
  int n_pass   = 0;

  microprocessor_sequencer #(
    .IDLE_ADDR (IDLE_MA),
    .GO_CYCLES (G),
    .TIMEOUT   (T)
  ) dut (
    .SYSTEM_CLK   (SYSTEM_CLK),
    .RESET_BAR    (RESET_BAR),
    .CMD_VALID    (CMD_VALID),
    .CMD_READY    (CMD_READY),
    .CMD_JAM      (CMD_JAM),
    .CMD_OPCODE   (CMD_OPCODE),
    .CMD_A        (CMD_A),
    .CMD_B        (CMD_B),
    .RSP_VALID    (RSP_VALID),
    .RSP_READY    (RSP_READY),
    .RSP_DATA     (RSP_DATA),
    .RSP_TIMEOUT  (RSP_TIMEOUT),
    .OPCODE       (OPCODE),
    .DATA_IN_A    (DATA_IN_A),
    .DATA_IN_B    (DATA_IN_B),
    .GO_BAR       (GO_BAR),
    .JAM          (JAM),
    .PROC_RESET   (PROC_RESET),
    .MICROADDRESS (MICROADDRESS),
    .DATA_OUT     (DATA_OUT),
    .BUSY         (BUSY)
  );

  always #5 SYSTEM_CLK = ~SYSTEM_CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Wait (bounded) for CMD_READY at a falling edge, then present and hold a command until accepted.
  task automatic send_cmd(input bit jam, input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge SYSTEM_CLK);
      if (CMD_READY === 1'b1) got = 1'b1;
    end
    check("cmd_ready_wait", 32'(got), 32'd1);
    CMD_VALID  = 1'b1;
    CMD_JAM    = jam;
    CMD_OPCODE = op;
    CMD_A      = a;
    CMD_B      = b;
    @(posedge SYSTEM_CLK);
    @(negedge SYSTEM_CLK);
    CMD_VALID  = 1'b0;
    CMD_JAM    = 1'($urandom);
    CMD_OPCODE = 4'($urandom);
    CMD_A      = 8'($urandom);
    CMD_B      = 8'($urandom);
  endtask

  // One full transaction. After GO_BAR returns high the processor model keeps
  // MICROADDRESS idle for d cycles, busy for r cycles, then idle with DATA_OUT=dout.
  // stuck=1 keeps it idle forever. hold = cycles of RSP_READY backpressure.
  task automatic run_cmd(input bit jam, input logic [3:0] op, input logic [7:0] a,
                         input logic [7:0] b, input int d, input int r,
                         input logic [7:0] dout, input int hold, input bit stuck);
    int         edges, go_low, jam_hi, pr_hi, k, wd_cycles, n, exp_lat;
    bit         started, aborted, ops_ok, busy_ok, stable_ok, got_rsp, exp_to;
    logic [7:0] exp_data, cap_data;
    logic       cap_to;

    edges = 0; go_low = 0; jam_hi = 0; pr_hi = 0; k = 0; wd_cycles = 0;
    started = 1'b0; aborted = 1'b0; ops_ok = 1'b1; busy_ok = 1'b1; got_rsp = 1'b0;

    // Expected outcome from the schedule alone.
    n = d + r + 1;
    if (jam) begin
      exp_lat = 1; exp_data = 8'h00; exp_to = 1'b0;
    end else if (stuck || n > T) begin
      exp_lat = G + T + 1; exp_data = 8'h00; exp_to = 1'b1;
    end else begin
      exp_lat = G + n; exp_data = dout; exp_to = 1'b0;
    end

    send_cmd(jam, op, a, b);

    // Now at the falling edge right after the accept edge; edges counts rising edges since then.
    for (int i = 0; i < 700 && !got_rsp; i++) begin
      if (RSP_VALID === 1'b1) begin
        got_rsp = 1'b1;
      end else begin
        if (GO_BAR === 1'b0) go_low++;
        if (JAM === 1'b1) jam_hi++;
        if (PROC_RESET === 1'b1) begin
          pr_hi++;
          if (!aborted) wd_cycles = k;
          aborted = 1'b1;
        end
        if (OPCODE !== op || DATA_IN_A !== a || DATA_IN_B !== b) ops_ok = 1'b0;
        if (CMD_READY !== 1'b0 || BUSY !== 1'b1) busy_ok = 1'b0;
        if (!jam && !started && go_low > 0 && GO_BAR === 1'b1) started = 1'b1;
        if (started && !aborted) begin
          if (stuck || k < d) begin
            MICROADDRESS = IDLE_MA;
            DATA_OUT     = 8'($urandom);
          end else if (k < d + r) begin
            MICROADDRESS = 8'($urandom_range(1, 255));
            DATA_OUT     = 8'($urandom);
          end else begin
            MICROADDRESS = IDLE_MA;
            DATA_OUT     = dout;
          end
          k++;
        end else begin
          MICROADDRESS = IDLE_MA;
        end
        @(negedge SYSTEM_CLK);
        edges++;
      end
    end

    check("rsp_seen", 32'(got_rsp), 32'd1);
    check("latency", 32'(edges), 32'(exp_lat));
    check("rsp_data", 32'(RSP_DATA), 32'(exp_data));
    check("rsp_timeout", 32'(RSP_TIMEOUT), 32'(exp_to));
    check("go_low_cycles", 32'(go_low), jam ? 32'd0 : 32'(G));
    check("jam_cycles", 32'(jam_hi), jam ? 32'd1 : 32'd0);
    check("proc_reset_cycles", 32'(pr_hi), exp_to ? 32'd1 : 32'd0);
    if (exp_to) check("watchdog_cycles", 32'(wd_cycles), 32'(T));
    check("operands_held", 32'(ops_ok), 32'd1);
    check("busy_not_ready", 32'(busy_ok), 32'd1);
    MICROADDRESS = IDLE_MA;

    // Backpressure: result and ready must stay frozen until the host takes it.
    cap_data  = RSP_DATA;
    cap_to    = RSP_TIMEOUT;
    stable_ok = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(negedge SYSTEM_CLK);
      if (RSP_VALID !== 1'b1 || RSP_DATA !== cap_data || RSP_TIMEOUT !== cap_to ||
          CMD_READY !== 1'b0) stable_ok = 1'b0;
    end
    if (hold > 0) check("rsp_stable", 32'(stable_ok), 32'd1);
    RSP_READY = 1'b1;
    @(negedge SYSTEM_CLK);
    RSP_READY = 1'b0;
    check("rsp_valid_after_hs", 32'(RSP_VALID), 32'd0);
    check("cmd_ready_after_hs", 32'(CMD_READY), 32'd1);
    check("rsp_data_retained", 32'(RSP_DATA), 32'(exp_data));
    $display("txn jam=%0d op=%0h a=%02h b=%02h d=%0d r=%0d stuck=%0d -> data=%02h to=%0d lat=%0d",
             jam, op, a, b, d, r, stuck, RSP_DATA, RSP_TIMEOUT, edges);
  endtask

  // Whole-run guard so the bench always terminates.
  initial begin
    #900000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    // Reset asserted asynchronously, before any clock edge.
    #2 RESET_BAR = 1'b0;
    #1;
    check("rst_go_bar", 32'(GO_BAR), 32'd1);
    check("rst_proc_reset", 32'(PROC_RESET), 32'd1);
    check("rst_cmd_ready", 32'(CMD_READY), 32'd0);
    check("rst_rsp_valid", 32'(RSP_VALID), 32'd0);
    check("rst_busy", 32'(BUSY), 32'd0);
    check("rst_opcode", 32'(OPCODE), 32'd0);
    @(negedge SYSTEM_CLK);
    @(negedge SYSTEM_CLK);
    RESET_BAR = 1'b1;
    @(negedge SYSTEM_CLK);
    check("post_rst_proc_reset", 32'(PROC_RESET), 32'd0);
    check("post_rst_cmd_ready", 32'(CMD_READY), 32'd1);
    check("post_rst_busy", 32'(BUSY), 32'd0);
    $display("reset sequence complete");

    // Execute 3/12/34, busy for 6 cycles, result 46, then 10 cycles of backpressure.
    run_cmd(1'b0, 4'h3, 8'h12, 8'h34, 0, 6, 8'h46, 10, 1'b0);
    // Minimum latency path.
    run_cmd(1'b0, 4'h5, 8'hA0, 8'h0B, 0, 1, 8'hC3, 0, 1'b0);
    // Jam.
    run_cmd(1'b1, 4'h9, 8'h77, 8'h88, 0, 0, 8'h00, 0, 1'b0);
    // Hung microprogram: address never leaves idle.
    run_cmd(1'b0, 4'h1, 8'h01, 8'h02, 0, 0, 8'h00, 2, 1'b1);
    // Exit on the very edge the watchdog would fire: exit wins.
    run_cmd(1'b0, 4'h2, 8'h5A, 8'hA5, 0, 254, 8'hE7, 0, 1'b0);
    // One cycle longer: watchdog wins.
    run_cmd(1'b0, 4'h4, 8'h11, 8'h22, 0, 255, 8'h99, 0, 1'b0);

    // Reset while GO_BAR is low.
    send_cmd(1'b0, 4'h6, 8'h33, 8'h44);
    check("go_low_before_reset", 32'(GO_BAR), 32'd0);
    RESET_BAR = 1'b0;
    #1;
    check("midrst_go_bar", 32'(GO_BAR), 32'd1);
    check("midrst_rsp_valid", 32'(RSP_VALID), 32'd0);
    check("midrst_proc_reset", 32'(PROC_RESET), 32'd1);
    check("midrst_cmd_ready", 32'(CMD_READY), 32'd0);
    check("midrst_opcode", 32'(OPCODE), 32'd0);
    @(negedge SYSTEM_CLK);
    RESET_BAR = 1'b1;
    $display("reset during launch complete");
    run_cmd(1'b0, 4'h7, 8'h3C, 8'hC3, 1, 3, 8'h5E, 1, 1'b0);

    // Reset while a result is pending.
    send_cmd(1'b1, 4'hA, 8'h01, 8'h02);
    @(negedge SYSTEM_CLK);
    check("pending_rsp_valid", 32'(RSP_VALID), 32'd1);
    RESET_BAR = 1'b0;
    #1;
    check("pending_rst_rsp_valid", 32'(RSP_VALID), 32'd0);
    check("pending_rst_busy", 32'(BUSY), 32'd0);
    @(negedge SYSTEM_CLK);
    RESET_BAR = 1'b1;
    $display("reset during respond complete");

    // Randomized commands.
    for (int t = 0; t < 24; t++) begin
      bit         rj;
      int         rd, rr, rh;
      rj = ($urandom_range(0, 3) == 0);
      rd = $urandom_range(0, 5);
      rr = $urandom_range(1, 8);
      rh = $urandom_range(0, 3);
      run_cmd(rj, 4'($urandom), 8'($urandom), 8'($urandom), rd, rr, 8'($urandom), rh, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
